// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV32M/RV64M multiply/divide unit: iterative radix-2 core with single-cycle special cases
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_IDEX,
    input  logic [2:0]      funct3_IDEX,
    input  logic [XLEN-1:0] rs1_data_IDEX,
    input  logic [XLEN-1:0] rs2_data_IDEX,
    input  logic [4:0]      rd_IDEX,
    input  logic            flush_EX,
    output logic            stall_EX,
    output logic            valid_EXMEM,
    output logic [XLEN-1:0] result_EXMEM,
    output logic [4:0]      rd_EXMEM
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [4:0]        rd_busy_q, rd_busy_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    // Operand decode: which operands are signed, their magnitudes and the result sign
    logic            is_div, a_signed, b_signed, a_neg, b_neg, neg_in;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;
    logic [2*XLEN-1:0] fast_prod_mag, fast_prod;

    assign is_div   = funct3_IDEX[2];
    assign a_signed = ~(funct3_IDEX[0] & (funct3_IDEX[1] | funct3_IDEX[2]));
    assign b_signed = (funct3_IDEX[1:0] == 2'b00) || (funct3_IDEX == 3'b001) || (funct3_IDEX == 3'b110);
    assign a_neg    = a_signed & rs1_data_IDEX[XLEN-1];
    assign b_neg    = b_signed & rs2_data_IDEX[XLEN-1];
    assign neg_in   = (is_div & funct3_IDEX[1]) ? a_neg : (a_neg ^ b_neg);
    assign a_mag    = a_neg ? -rs1_data_IDEX : rs1_data_IDEX;
    assign b_mag    = b_neg ? -rs2_data_IDEX : rs2_data_IDEX;

    assign div_zero = is_div && (rs2_data_IDEX == '0);
    assign div_ovf  = is_div && !funct3_IDEX[0]
                      && (rs1_data_IDEX == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_IDEX == '1);
    assign fast     = (!is_div && (FAST_MUL != 0)) || div_zero || div_ovf;

    assign fast_prod_mag = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    assign fast_prod     = neg_in ? -fast_prod_mag : fast_prod_mag;

    always_comb begin
        fast_res = fast_prod[2*XLEN-1:XLEN];
        if (div_zero)
            fast_res = funct3_IDEX[1] ? rs1_data_IDEX : '1;
        else if (div_ovf)
            fast_res = funct3_IDEX[1] ? '0 : rs1_data_IDEX;
        else if (funct3_IDEX[1:0] == 2'b00)
            fast_res = fast_prod[XLEN-1:0];
    end

    // acc holds {high product, multiplier} for multiply and {remainder, quotient} for divide
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] mul_next, div_next, acc_step, mul_fin;
    logic [XLEN-1:0]   quot_fin, rem_fin, iter_res;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    assign div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign acc_step  = op_q[2] ? div_next : mul_next;
    assign mul_fin   = neg_q ? -acc_step : acc_step;
    assign quot_fin  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    assign rem_fin   = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

    always_comb begin
        if (op_q[2])
            iter_res = op_q[1] ? rem_fin : quot_fin;
        else if (op_q[1:0] == 2'b00)
            iter_res = mul_fin[XLEN-1:0];
        else
            iter_res = mul_fin[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        b_d       = b_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rd_busy_d = rd_busy_q;
        valid_d   = 1'b0;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        stall_EX  = 1'b0;
        if (flush_EX) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_IDEX) begin
                        if (fast) begin
                            valid_d  = 1'b1;
                            result_d = fast_res;
                            rd_out_d = rd_IDEX;
                        end else begin
                            stall_EX  = 1'b1;
                            acc_d     = {{XLEN{1'b0}}, a_mag};
                            b_d       = b_mag;
                            op_d      = funct3_IDEX;
                            neg_d     = neg_in;
                            rd_busy_d = rd_IDEX;
                            count_d   = CW'(XLEN - 1);
                            state_d   = BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_d = acc_step;
                    if (count_q != '0) begin
                        stall_EX = 1'b1;
                        count_d  = count_q - CW'(1);
                    end else begin
                        valid_d  = 1'b1;
                        result_d = iter_res;
                        rd_out_d = rd_busy_q;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rd_busy_q <= '0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rd_busy_q <= rd_busy_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
        end
    end

    assign valid_EXMEM  = valid_q;
    assign result_EXMEM = result_q;
    assign rd_EXMEM     = rd_out_q;
endmodule
